// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for a subtract-based GCD datapath.
// It loads operands A and B from data_in over an op_valid/op_ready handshake.
// It then issues one subtraction per clock, steered by the lt/gt/eq comparator.
// It flags err if the run needs more than MAX_ITER-1 subtractions.
// Optional feature macro: GCD_ITER_COUNT_EN adds the iter_count output.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// LOAD_A | accepting operand A from data_in (op_ready=1)
// LOAD_B | accepting operand B from data_in (op_ready=1)
// CALC   | one subtraction per clock until A==B or the bound is hit
// DONE   | result valid on datapath A; held until start
// ERR    | iteration bound exceeded; held until start
module gcd_controller #(
  parameter int MAX_ITER = 1024,
  parameter int ITER_W   = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              lt,
  input  logic              gt,
  input  logic              eq,
  output logic              sel1,
  output logic              sel2,
  output logic              sel_in,
  output logic              ldA,
  output logic              ldB,
  output logic              done,
  output logic              busy,
`ifdef GCD_ITER_COUNT_EN
  output logic [ITER_W-1:0] iter_count,
`endif
  output logic              err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_CALC   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  // Counter value at which a further subtraction would exceed the bound.
  localparam logic [ITER_W-1:0] CNT_LAST = ITER_W'(MAX_ITER - 1);

  logic [2:0]        state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              done_q, busy_q, err_q;

  // Next-state, counter and Mealy datapath-control decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_ready = 1'b0;
    sel1     = 1'b0;
    sel2     = 1'b0;
    sel_in   = 1'b0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        op_ready = 1'b1;
        ldA      = op_valid;
        if (op_valid) state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        op_ready = 1'b1;
        ldB      = op_valid;
        if (op_valid) begin
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // No comparator flag at all is treated like eq, so the FSM cannot hang.
        if (eq || !(gt || lt)) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // The subtraction that would exceed the bound is suppressed.
          state_d = S_ERR;
        end else if (gt) begin
          sel1   = 1'b1;
          sel_in = 1'b1;
          ldA    = 1'b1;
          cnt_d  = cnt_q + ITER_W'(1);
        end else begin
          sel2   = 1'b1;
          sel_in = 1'b1;
          ldB    = 1'b1;
          cnt_d  = cnt_q + ITER_W'(1);
        end
      end
      S_DONE, S_ERR: begin
        if (start) state_d = S_LOAD_A;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The state register and the counter. Status flags are registered from
  // state_d so that done/busy/err come straight off flops and cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == S_DONE);
      busy_q  <= (state_d == S_LOAD_A) || (state_d == S_LOAD_B) || (state_d == S_CALC);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign done = done_q;
  assign busy = busy_q;
  assign err  = err_q;

`ifdef GCD_ITER_COUNT_EN
  // The counter clears on the LOAD_B accept and is frozen in DONE/ERR.
  // It therefore already holds the subtraction count of the last run.
  assign iter_count = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: directed bench for gcd_controller.
// It includes a behavioural subtract-GCD datapath, so results can be checked end to end.
module tb_gcd_controller;

  localparam int MAXI = 16;
  localparam int IW   = 5;
  localparam int BUDGET = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic op_valid = 1'b0;
  logic op_ready, lt, gt, eq, sel1, sel2, sel_in, ldA, ldB, done, busy, err;
`ifdef GCD_ITER_COUNT_EN
  logic [IW-1:0] iter_count;
`endif

  logic [7:0] data_in = 8'd0;
  logic [7:0] ra = 8'd0;
  logic [7:0] rb = 8'd0;
  logic [7:0] sub;
  int n_lda = 0;
  int n_ldb = 0;

  int n_checks = 0;
  int n_errors = 0;
  int edges, na0, nb0;

  gcd_controller #(.MAX_ITER(MAXI), .ITER_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid), .op_ready(op_ready),
    .lt(lt), .gt(gt), .eq(eq), .sel1(sel1), .sel2(sel2), .sel_in(sel_in),
    .ldA(ldA), .ldB(ldB), .done(done), .busy(busy),
`ifdef GCD_ITER_COUNT_EN
    .iter_count(iter_count),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  // Datapath model: subtractor, register bus mux, A/B registers, comparator.
  assign sub = (sel1 ? ra : rb) - (sel2 ? ra : rb);
  assign lt  = ra < rb;
  assign gt  = ra > rb;
  assign eq  = ra == rb;

  always @(posedge clk) begin
    if (ldA) begin
      ra <= sel_in ? sub : data_in;
      n_lda <= n_lda + 1;
    end
    if (ldB) begin
      rb <= sel_in ? sub : data_in;
      n_ldb <= n_ldb + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle (called at a negedge, returns at a negedge).
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present A then B on consecutive cycles. Returns at the negedge after the B accept.
  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    op_valid = 1'b1;
    data_in  = a;
    @(negedge clk);
    data_in  = b;
    @(negedge clk);
    op_valid = 1'b0;
    na0 = n_lda;
    nb0 = n_ldb;
  endtask

  // Count clock edges until done or err, starting from a given count.
  task automatic wait_end(input int first, output int e);
    e = first;
    while (!(done || err) && e < BUDGET) begin
      @(negedge clk);
      e++;
    end
    chk("timeout", 32'(e < BUDGET), 32'd1);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_outs", {op_ready, sel1, sel2, sel_in, ldA, ldB, done, busy, err}, 9'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // op_valid while IDLE is ignored.
    op_valid = 1'b1;
    data_in  = 8'd55;
    @(negedge clk);
    op_valid = 1'b0;
    chk("idle_ignore_valid", {op_ready, busy, 1'b0}, 3'b000);
    chk("idle_no_load", 32'(n_lda), 32'd0);

    // 48,18: ldA,ldA,ldB,ldA; done 5 edges after the accept; result 6.
    do_start();
    chk("loada_ready", {op_ready, busy}, 2'b11);
    load_ops(8'd48, 8'd18);
    chk("calc_busy", {busy, done}, 2'b10);
    wait_end(0, edges);
    chk("g48_latency", 32'(edges), 32'd5);
    chk("g48_flags", {done, err, busy}, 3'b100);
    chk("g48_result", 32'(ra), 32'd6);
    chk("g48_lda", 32'(n_lda - na0), 32'd3);
    chk("g48_ldb", 32'(n_ldb - nb0), 32'd1);
`ifdef GCD_ITER_COUNT_EN
    chk("g48_iter", 32'(iter_count), 32'd4);
`endif

    // 7,7: no subtraction; done 1 edge after the accept.
    do_start();
    chk("restart_done_low", {done, op_ready}, 2'b01);
    load_ops(8'd7, 8'd7);
    wait_end(0, edges);
    chk("g7_latency", 32'(edges), 32'd1);
    chk("g7_result", 32'(ra), 32'd7);
    chk("g7_no_ld", 32'(n_lda - na0 + n_ldb - nb0), 32'd0);

    // 13,0 with MAX_ITER=16: 15 ldA pulses, then err.
    do_start();
    load_ops(8'd13, 8'd0);
    chk("gt_ctrl", {sel1, sel2, sel_in, ldA, ldB}, 5'b10110);
    wait_end(0, edges);
    chk("err_latency", 32'(edges), 32'd16);
    chk("err_flags", {err, done, busy}, 3'b100);
    chk("err_lda", 32'(n_lda - na0), 32'd15);
`ifdef GCD_ITER_COUNT_EN
    chk("err_iter", 32'(iter_count), 32'd15);
`endif
    @(negedge clk);
    chk("err_held", {err, ldA}, 2'b10);
    do_start();
    chk("err_cleared", {err, op_ready, busy}, 3'b011);

    // op_valid low for 3 cycles in LOAD_A: stays ready, no ldA.
    na0 = n_lda;
    for (int i = 0; i < 3; i++) begin
      chk("wait_ready", {op_ready, ldA}, 2'b10);
      @(negedge clk);
    end
    chk("wait_no_lda", 32'(n_lda - na0), 32'd0);

    // 100,75 with a start pulse during CALC: ignored; result 25 after 3 subtractions.
    load_ops(8'd100, 8'd75);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_calc", {busy, done, op_ready}, 3'b100);
    wait_end(1, edges);
    chk("g100_latency", 32'(edges), 32'd4);
    chk("g100_result", 32'(ra), 32'd25);

    // A second start in DONE drops done and re-enters LOAD_A.
    do_start();
    chk("done_restart", {done, op_ready, busy}, 3'b011);

    // A reset mid-CALC aborts at once.
    load_ops(8'd13, 8'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {op_ready, sel1, sel2, sel_in, ldA, ldB, done, busy, err}, 9'd0);
    @(negedge clk);
    chk("reset_held", {op_ready, sel1, sel2, sel_in, ldA, ldB, done, busy, err}, 9'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {op_ready, busy}, 2'b00);

    // Normal run after the reset: 9,3 gives result 3 after 2 subtractions.
    do_start();
    load_ops(8'd9, 8'd3);
    wait_end(0, edges);
    chk("g9_latency", 32'(edges), 32'd3);
    chk("g9_result", 32'(ra), 32'd3);
    chk("g9_flags", {done, err}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
